// File: rtl/yarp_pkg.sv
// Shared types and constants for the yarp data-memory responder.
package yarp_pkg;

  typedef enum logic [1:0] {
    BYTE      = 2'b00,
    HALF_WORD = 2'b01,
    WORD      = 2'b11
  } mem_access_size_t;

  localparam logic [3:0] MMIO_CYCLE_LO    = 4'h0;
  localparam logic [3:0] MMIO_CYCLE_HI    = 4'h4;
  localparam logic [3:0] MMIO_TEST_STATUS = 4'h8;
  localparam logic [3:0] MMIO_ERR_ADDR    = 4'hC;

endpackage

// File: rtl/yarp_dmem_bank.sv
// Word-wide data array built from four byte-lane arrays; per-lane write enable,
// asynchronous read of the full word.
module yarp_dmem_bank #(
  parameter int DEPTH_WORDS = 1024,
  localparam int AW = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic [3:0]    i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] r_lane [DEPTH_WORDS];

      always_ff @(posedge clk) begin
        if (i_we[gi]) begin
          r_lane[i_addr] <= i_wdata[8*gi +: 8];
        end
      end

      assign o_rdata[8*gi +: 8] = r_lane[i_addr];
    end
  endgenerate

endmodule

// File: rtl/yarp_dmem_responder.sv
// Memory-side responder for the core's data-memory port: on-chip word array plus a
// small MMIO window (cycle counter, test status, sticky error capture).
module yarp_dmem_responder
  import yarp_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] MEM_BASE    = 32'h0000_2000,
  parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_mem_req_i,
  input  logic [31:0] data_mem_addr_i,
  input  logic [1:0]  data_mem_byte_en_i,
  input  logic        data_mem_wr_i,
  input  logic [31:0] data_mem_wr_data_i,
  output logic [31:0] data_mem_rd_data_o,
  output logic        test_done_o,
  output logic        test_pass_o,
  output logic        access_err_o,
  output logic [31:0] err_addr_o
);

  localparam int AW = $clog2(DEPTH_WORDS);

  logic [63:0]      r_cycle;
  logic             r_done;
  logic             r_pass;
  logic             r_err;
  logic [31:0]      r_err_addr;

  mem_access_size_t w_size;
  logic             w_mem_hit;
  logic             w_mmio_hit;
  logic             w_size_err;
  logic             w_align_err;
  logic             w_err;
  logic             w_ok;
  logic [3:0]       w_lane_mask;
  logic [3:0]       w_bank_we;
  logic [31:0]      w_bank_wdata;
  logic [31:0]      w_bank_rdata;
  logic [31:0]      w_mem_rdata;
  logic [31:0]      w_mmio_rdata;
  logic             w_status_wr;

  assign w_size = mem_access_size_t'(data_mem_byte_en_i);

  // MEM_BASE is aligned to the array size, so a prefix compare is an exact range check.
  assign w_mem_hit  = (data_mem_addr_i[31:AW+2] == MEM_BASE[31:AW+2]);
  assign w_mmio_hit = (data_mem_addr_i[31:4] == MMIO_BASE[31:4]);

  always_comb begin
    w_size_err  = 1'b0;
    w_align_err = 1'b0;
    w_lane_mask = 4'b0000;
    case (w_size)
      BYTE: begin
        w_lane_mask = 4'b0001 << data_mem_addr_i[1:0];
      end
      HALF_WORD: begin
        w_align_err = data_mem_addr_i[0];
        w_lane_mask = 4'b0011 << {data_mem_addr_i[1], 1'b0};
      end
      WORD: begin
        w_align_err = |data_mem_addr_i[1:0];
        w_lane_mask = 4'b1111;
      end
      default: begin
        w_size_err = 1'b1;
      end
    endcase
  end

  assign w_err = data_mem_req_i &
                 (w_size_err | w_align_err | (~w_mem_hit & ~w_mmio_hit) |
                  (w_mmio_hit & (w_size != WORD)));
  assign w_ok  = data_mem_req_i & ~w_err;

  // Gating with reset drops a store that coincides with reset assertion.
  assign w_bank_we    = {4{w_ok & data_mem_wr_i & w_mem_hit & ~reset}} & w_lane_mask;
  assign w_bank_wdata = data_mem_wr_data_i << {data_mem_addr_i[1:0], 3'b000};

  yarp_dmem_bank #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_bank (
    .clk    (clk),
    .i_we   (w_bank_we),
    .i_addr (data_mem_addr_i[AW+1:2]),
    .i_wdata(w_bank_wdata),
    .o_rdata(w_bank_rdata)
  );

  assign w_mem_rdata = w_bank_rdata >> {data_mem_addr_i[1:0], 3'b000};

  always_comb begin
    w_mmio_rdata = 32'h0;
    case (data_mem_addr_i[3:0])
      MMIO_CYCLE_LO: w_mmio_rdata = r_cycle[31:0];
      MMIO_CYCLE_HI: w_mmio_rdata = r_cycle[63:32];
      MMIO_ERR_ADDR: w_mmio_rdata = r_err_addr;
      default:       w_mmio_rdata = 32'h0;
    endcase
  end

  always_comb begin
    data_mem_rd_data_o = 32'h0;
    if (w_ok && !data_mem_wr_i) begin
      data_mem_rd_data_o = w_mem_hit ? w_mem_rdata : w_mmio_rdata;
    end
  end

  assign w_status_wr = w_ok & data_mem_wr_i & w_mmio_hit &
                       (data_mem_addr_i[3:0] == MMIO_TEST_STATUS);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cycle    <= 64'h0;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
      r_err      <= 1'b0;
      r_err_addr <= 32'h0;
    end else begin
      r_cycle <= r_cycle + 64'd1;
      if (w_err && !r_err) begin
        r_err      <= 1'b1;
        r_err_addr <= data_mem_addr_i;
      end
      if (w_status_wr && !r_done) begin
        r_done <= 1'b1;
        r_pass <= (data_mem_wr_data_i == 32'h1);
      end
    end
  end

  assign test_done_o  = r_done;
  assign test_pass_o  = r_pass;
  assign access_err_o = r_err;
  assign err_addr_o   = r_err_addr;

endmodule

// File: tb/tb_yarp_dmem_responder.sv
// Scoreboard bench for yarp_dmem_responder: stimulus pushes expectations, a negedge monitor checks them.
module tb_yarp_dmem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic [31:0] addr;
  logic [1:0]  be;
  logic        wr;
  logic [31:0] wdata;
  logic [31:0] rd_data;
  logic        done;
  logic        pass;
  logic        err;
  logic [31:0] err_addr;

  yarp_dmem_responder dut (
    .clk               (clk),
    .reset             (reset),
    .data_mem_req_i    (req),
    .data_mem_addr_i   (addr),
    .data_mem_byte_en_i(be),
    .data_mem_wr_i     (wr),
    .data_mem_wr_data_i(wdata),
    .data_mem_rd_data_o(rd_data),
    .test_done_o       (done),
    .test_pass_o       (pass),
    .access_err_o      (err),
    .err_addr_o        (err_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } ld_exp_t;

  typedef struct {
    string       name;
    logic        err;
    logic        done;
    logic        pass;
    logic [31:0] eaddr;
  } st_exp_t;

  ld_exp_t ld_q[$];
  st_exp_t st_q[$];
  ld_exp_t le;
  st_exp_t se;
  logic    chk_status;
  int      tests = 0;
  int      fails = 0;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  // Monitor: every load cycle and every status strobe consumes one expectation.
  always @(negedge clk) begin
    if (req && !wr) begin
      if (ld_q.size() == 0) begin
        tests++;
        fails++;
        $display("[TB] FAIL unexpected_load: addr 0x%08h rd 0x%08h, no expectation queued", addr, rd_data);
      end else begin
        le = ld_q.pop_front();
        $display("[TB] load  %-14s addr=0x%08h be=%b rd=0x%08h exp=0x%08h", le.name, addr, be, rd_data, le.exp);
        cmp(le.name, rd_data, le.exp);
      end
    end
    if (chk_status) begin
      if (st_q.size() == 0) begin
        tests++;
        fails++;
        $display("[TB] FAIL unexpected_status: no expectation queued");
      end else begin
        se = st_q.pop_front();
        $display("[TB] status %-13s err=%b eaddr=0x%08h done=%b pass=%b", se.name, err, err_addr, done, pass);
        cmp({se.name, "_err"},   {31'h0, err},  {31'h0, se.err});
        cmp({se.name, "_eaddr"}, err_addr,      se.eaddr);
        cmp({se.name, "_done"},  {31'h0, done}, {31'h0, se.done});
        cmp({se.name, "_pass"},  {31'h0, pass}, {31'h0, se.pass});
        if (!req) cmp({se.name, "_idle_rd"}, rd_data, 32'h0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input string nm, input logic [31:0] a, input logic [1:0] sz,
                         input logic [31:0] exp);
    ld_exp_t e;
    e.name = nm;
    e.exp  = exp;
    ld_q.push_back(e);
    req  = 1'b1;
    wr   = 1'b0;
    addr = a;
    be   = sz;
    tick();
    req  = 1'b0;
  endtask

  task automatic do_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
    $display("[TB] store addr=0x%08h be=%b data=0x%08h", a, sz, d);
    req   = 1'b1;
    wr    = 1'b1;
    addr  = a;
    be    = sz;
    wdata = d;
    tick();
    req   = 1'b0;
    wr    = 1'b0;
  endtask

  task automatic check_status(input string nm, input logic e, input logic d, input logic p,
                              input logic [31:0] ea);
    st_exp_t s;
    s.name  = nm;
    s.err   = e;
    s.done  = d;
    s.pass  = p;
    s.eaddr = ea;
    st_q.push_back(s);
    chk_status = 1'b1;
    tick();
    chk_status = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; req = 1'b0; wr = 1'b0; addr = 32'h0; be = 2'b00; wdata = 32'h0;
    chk_status = 1'b0;
    repeat (2) tick();
    check_status("reset", 1'b0, 1'b0, 1'b0, 32'h0);

    // Counter: 10 edges after release, then CYCLE_LO shows 10.
    reset = 1'b0;
    repeat (10) tick();
    do_load("cycle_lo_10", 32'hFFFF_0000, 2'b11, 32'd10);
    do_load("cycle_hi",    32'hFFFF_0004, 2'b11, 32'd0);
    do_store(32'hFFFF_0000, 2'b11, 32'h1234_5678);
    do_load("cycle_lo_13", 32'hFFFF_0000, 2'b11, 32'd13);
    do_load("status_rd0",  32'hFFFF_0008, 2'b11, 32'h0);
    do_load("erraddr_rd0", 32'hFFFF_000C, 2'b11, 32'h0);
    check_status("mmio_ro", 1'b0, 1'b0, 1'b0, 32'h0);

    do_store(32'hFFFF_0008, 2'b11, 32'h1);
    check_status("test_pass", 1'b0, 1'b1, 1'b1, 32'h0);
    do_store(32'hFFFF_0008, 2'b11, 32'h0);
    check_status("done_sticky", 1'b0, 1'b1, 1'b1, 32'h0);

    do_store(32'h2000, 2'b11, 32'hDEAD_BEEF);
    do_load("raw_word",  32'h2000, 2'b11, 32'hDEAD_BEEF);
    do_store(32'h2002, 2'b00, 32'hFFFF_FF55);
    do_load("byte_merge", 32'h2000, 2'b11, 32'hDE55_BEEF);
    do_load("byte_ld3",   32'h2003, 2'b00, 32'h0000_00DE);
    do_load("byte_ld2",   32'h2002, 2'b00, 32'h0000_DE55);
    do_load("half_ld0",   32'h2000, 2'b01, 32'hDE55_BEEF);

    do_store(32'h2006, 2'b01, 32'hABCD_1234);
    do_load("half_ld6",   32'h2006, 2'b01, 32'h0000_1234);
    do_store(32'h2004, 2'b01, 32'h0000_7788);
    do_load("half_merge", 32'h2004, 2'b11, 32'h1234_7788);

    do_store(32'h2010, 2'b11, 32'hA5A5_A5A5);
    do_load("a5_word",    32'h2010, 2'b11, 32'hA5A5_A5A5);
    do_store(32'h2FFC, 2'b11, 32'hCAFE_F00D);
    do_load("top_word",   32'h2FFC, 2'b11, 32'hCAFE_F00D);
    check_status("no_err", 1'b0, 1'b1, 1'b1, 32'h0);

    do_load("half_mis",   32'h2005, 2'b01, 32'h0);
    check_status("first_err", 1'b1, 1'b1, 1'b1, 32'h2005);

    // Reset asserted in the same cycle as a store: the store must be dropped.
    $display("[TB] store addr=0x00002010 be=11 data=0x11111111 with reset asserted");
    req = 1'b1; wr = 1'b1; addr = 32'h2010; be = 2'b11; wdata = 32'h1111_1111; reset = 1'b1;
    tick();
    req = 1'b0; wr = 1'b0;
    tick();
    check_status("reset2", 1'b0, 1'b0, 1'b0, 32'h0);
    reset = 1'b0;
    tick();
    do_load("a5_kept",    32'h2010, 2'b11, 32'hA5A5_A5A5);

    do_load("unmapped",   32'h0000_0100, 2'b11, 32'h0);
    check_status("unmapped", 1'b1, 1'b0, 1'b0, 32'h100);
    do_load("word_mis",   32'h2001, 2'b11, 32'h0);
    check_status("keep_addr", 1'b1, 1'b0, 1'b0, 32'h100);

    do_store(32'h2012, 2'b11, 32'h9999_9999);
    do_load("mis_st_drop", 32'h2010, 2'b11, 32'hA5A5_A5A5);
    do_store(32'h2010, 2'b10, 32'h0);
    do_load("ill_st_drop", 32'h2010, 2'b11, 32'hA5A5_A5A5);
    do_load("below_mem",  32'h1FFC, 2'b11, 32'h0);
    do_load("above_mem",  32'h3000, 2'b11, 32'h0);
    do_load("mmio_byte",  32'hFFFF_000C, 2'b00, 32'h0);
    do_load("erraddr_rd", 32'hFFFF_000C, 2'b11, 32'h100);

    do_store(32'hFFFF_0008, 2'b11, 32'h2);
    check_status("test_fail", 1'b1, 1'b1, 1'b0, 32'h100);

    repeat (3) tick();
    tests++;
    if (ld_q.size() != 0 || st_q.size() != 0) begin
      fails++;
      $display("[TB] FAIL drain: %0d loads and %0d status checks left unconsumed", ld_q.size(), st_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
